// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter
// Shares one external burst memory bus between icache refills, dcache refill/uncached reads and
// dcache writebacks/uncached stores. One transaction is in flight at a time. The dcache write
// beats its own read so an evicted dirty line reaches memory before the refill that replaces it.
// A starvation counter stops a busy dcache from locking out a pending icache refill for long.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LEN_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  // icache read port
  input  logic             ic_rd_req,
  input  logic [31:0]      ic_rd_addr,
  input  logic [LEN_W-1:0] ic_rd_len,
  output logic             ic_rd_gnt,
  // dcache read port
  input  logic             dc_rd_req,
  input  logic [31:0]      dc_rd_addr,
  input  logic [LEN_W-1:0] dc_rd_len,
  output logic             dc_rd_gnt,
  // dcache write port
  input  logic             dc_wr_req,
  input  logic [31:0]      dc_wr_addr,
  input  logic [LEN_W-1:0] dc_wr_len,
  output logic             dc_wr_gnt,
  input  logic [31:0]      dc_wr_data,
  output logic             dc_wr_next,
  // read return, shared by both readers
  output logic [31:0]      ret_data,
  output logic             ic_ret_valid,
  output logic             dc_ret_valid,
  output logic             ret_last,
  // external memory bus
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [LEN_W-1:0] bus_len,
  input  logic             bus_ready,
  output logic [31:0]      bus_wdata,
  output logic             bus_wvalid,
  output logic             bus_wlast,
  input  logic             bus_wready,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_rvalid,
  input  logic             bus_rlast
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_RDATA = 2'd2,
    S_WDATA = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IC    = 2'd1,
    OWN_DC_RD = 2'd2,
    OWN_DC_WR = 2'd3
  } owner_e;

  state_e           state_q,  state_d;
  owner_e           owner_q,  owner_d;
  logic [31:0]      addr_q,   addr_d;
  logic [LEN_W-1:0] len_q,    len_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic [LEN_W-1:0] beat_q,   beat_d;

  // Exposed under the historical names so debug probes keep working.
  logic [SC_W-1:0]  starve_cnt_q;
  logic [LEN_W-1:0] beat_cnt_q;
  assign starve_cnt_q = starve_q;
  assign beat_cnt_q   = beat_q;

  logic last_beat;
  logic ic_starved;
  logic owner_req;

  assign last_beat  = (beat_q == len_q);
  assign ic_starved = ic_rd_req && (starve_q == STARVE_MAX);

  // Request line of whichever requester currently owns the command phase.
  always_comb begin
    owner_req = 1'b0;
    unique case (owner_q)
      OWN_IC:    owner_req = ic_rd_req;
      OWN_DC_RD: owner_req = dc_rd_req;
      OWN_DC_WR: owner_req = dc_wr_req;
      default:   owner_req = 1'b0;
    endcase
  end

  // State, ownership, command fields and counters.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the command fields are reset along with the control state; all are small flops, and a
  // defined value keeps the bus side free of X after power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      len_q    <= '0;
      starve_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
    end
  end

  // Arbitration, command handshake, beat routing and next-state selection.
  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    len_d        = len_q;
    starve_d     = starve_q;
    beat_d       = beat_q;
    ic_rd_gnt    = 1'b0;
    dc_rd_gnt    = 1'b0;
    dc_wr_gnt    = 1'b0;
    dc_wr_next   = 1'b0;
    ret_data     = '0;
    ic_ret_valid = 1'b0;
    dc_ret_valid = 1'b0;
    ret_last     = 1'b0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_len      = '0;
    bus_wdata    = '0;
    bus_wvalid   = 1'b0;
    bus_wlast    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // No icache request means no starvation history to keep.
        if (!ic_rd_req) begin
          starve_d = '0;
        end
        if (ic_starved) begin
          owner_d = OWN_IC;
          addr_d  = ic_rd_addr;
          len_d   = ic_rd_len;
          state_d = S_CMD;
        end else if (dc_wr_req) begin
          // Writes first: a dirty victim must land before its refill read.
          owner_d = OWN_DC_WR;
          addr_d  = dc_wr_addr;
          len_d   = dc_wr_len;
          state_d = S_CMD;
        end else if (dc_rd_req) begin
          owner_d = OWN_DC_RD;
          addr_d  = dc_rd_addr;
          len_d   = dc_rd_len;
          state_d = S_CMD;
        end else if (ic_rd_req) begin
          owner_d = OWN_IC;
          addr_d  = ic_rd_addr;
          len_d   = ic_rd_len;
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        bus_req  = 1'b1;
        bus_we   = (owner_q == OWN_DC_WR);
        bus_addr = addr_q;
        bus_len  = len_q;
        if (bus_ready) begin
          beat_d = '0;
          unique case (owner_q)
            OWN_IC: begin
              ic_rd_gnt = 1'b1;
              starve_d  = '0;
              state_d   = S_RDATA;
            end
            OWN_DC_RD: begin
              dc_rd_gnt = 1'b1;
              if (ic_rd_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
              end
              state_d = S_RDATA;
            end
            OWN_DC_WR: begin
              dc_wr_gnt = 1'b1;
              if (ic_rd_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
              end
              state_d = S_WDATA;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end

      S_RDATA: begin
        // Beats are not counted; the bus marks the end of the burst.
        ret_data     = bus_rdata;
        ic_ret_valid = bus_rvalid && (owner_q == OWN_IC);
        dc_ret_valid = bus_rvalid && (owner_q == OWN_DC_RD);
        ret_last     = bus_rvalid && bus_rlast;
        if (bus_rvalid && bus_rlast) begin
          owner_d = OWN_NONE;
          state_d = S_IDLE;
        end
      end

      S_WDATA: begin
        bus_wvalid = 1'b1;
        bus_wdata  = dc_wr_data;
        bus_wlast  = last_beat;
        if (bus_wready) begin
          dc_wr_next = 1'b1;
          beat_d     = beat_q + 1'b1;
          if (last_beat) begin
            owner_d = OWN_NONE;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // A requester may not withdraw its request while its command is waiting on the bus.
  a_req_held_until_gnt: assert property (
    @(posedge clk) disable iff (rst) (state_q == S_CMD) |-> owner_req
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_bus_arbiter. Inputs change 1ns after the rising edge, outputs are
// checked on the falling edge (or 1ns after a mid-cycle input change).
module tb_mem_bus_arbiter;
  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ic_rd_req,  dc_rd_req,  dc_wr_req;
  logic [31:0]      ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [LEN_W-1:0] ic_rd_len,  dc_rd_len,  dc_wr_len;
  logic             ic_rd_gnt,  dc_rd_gnt,  dc_wr_gnt;
  logic [31:0]      dc_wr_data;
  logic             dc_wr_next;
  logic [31:0]      ret_data;
  logic             ic_ret_valid, dc_ret_valid, ret_last;
  logic             bus_req, bus_we;
  logic [31:0]      bus_addr;
  logic [LEN_W-1:0] bus_len;
  logic             bus_ready;
  logic [31:0]      bus_wdata;
  logic             bus_wvalid, bus_wlast, bus_wready;
  logic [31:0]      bus_rdata;
  logic             bus_rvalid, bus_rlast;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_rd_req    (ic_rd_req),
    .ic_rd_addr   (ic_rd_addr),
    .ic_rd_len    (ic_rd_len),
    .ic_rd_gnt    (ic_rd_gnt),
    .dc_rd_req    (dc_rd_req),
    .dc_rd_addr   (dc_rd_addr),
    .dc_rd_len    (dc_rd_len),
    .dc_rd_gnt    (dc_rd_gnt),
    .dc_wr_req    (dc_wr_req),
    .dc_wr_addr   (dc_wr_addr),
    .dc_wr_len    (dc_wr_len),
    .dc_wr_gnt    (dc_wr_gnt),
    .dc_wr_data   (dc_wr_data),
    .dc_wr_next   (dc_wr_next),
    .ret_data     (ret_data),
    .ic_ret_valid (ic_ret_valid),
    .dc_ret_valid (dc_ret_valid),
    .ret_last     (ret_last),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_len      (bus_len),
    .bus_ready    (bus_ready),
    .bus_wdata    (bus_wdata),
    .bus_wvalid   (bus_wvalid),
    .bus_wlast    (bus_wlast),
    .bus_wready   (bus_wready),
    .bus_rdata    (bus_rdata),
    .bus_rvalid   (bus_rvalid),
    .bus_rlast    (bus_rlast)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // All outputs are quiet (reset or idle).
  task automatic check_quiet(input string tag);
    check({tag, " ctl"}, {20'd0, ic_rd_gnt, dc_rd_gnt, dc_wr_gnt, dc_wr_next, ic_ret_valid,
                          dc_ret_valid, ret_last, bus_req, bus_we, bus_wvalid, bus_wlast, 1'b0}, 32'd0);
    check({tag, " ret_data"},  ret_data,  32'd0);
    check({tag, " bus_addr"},  bus_addr,  32'd0);
    check({tag, " bus_len"},   {29'd0, bus_len}, 32'd0);
    check({tag, " bus_wdata"}, bus_wdata, 32'd0);
  endtask

  // Entered at an IDLE cycle with requests already set: one idle cycle, then the command,
  // bus_ready withheld for 'delay' cycles. exp_gnt = {ic, dc_rd, dc_wr}.
  task automatic do_cmd(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                        input logic [LEN_W-1:0] exp_len, input int delay, input logic [2:0] exp_gnt);
    sample();
    check({tag, " idle gap"}, {31'd0, bus_req}, 32'd0);
    tick();
    sample();
    for (int i = 0; i < delay; i++) begin
      check({tag, " wait req"},  {31'd0, bus_req}, 32'd1);
      check({tag, " wait addr"}, bus_addr, exp_addr);
      check({tag, " wait gnt"},  {29'd0, ic_rd_gnt, dc_rd_gnt, dc_wr_gnt}, 32'd0);
      tick();
      sample();
    end
    bus_ready = 1'b1;
    #1;
    check({tag, " req"},  {31'd0, bus_req}, 32'd1);
    check({tag, " we"},   {31'd0, bus_we},  {31'd0, exp_we});
    check({tag, " addr"}, bus_addr, exp_addr);
    check({tag, " len"},  {29'd0, bus_len}, {29'd0, exp_len});
    check({tag, " gnt"},  {29'd0, ic_rd_gnt, dc_rd_gnt, dc_wr_gnt}, {29'd0, exp_gnt});
    tick();
    bus_ready = 1'b0;
    if (exp_gnt[2]) ic_rd_req = 1'b0;
    if (exp_gnt[1]) dc_rd_req = 1'b0;
    if (exp_gnt[0]) dc_wr_req = 1'b0;
  endtask

  // Returns n read beats back to back; ends at the following IDLE cycle.
  task automatic do_read(input string tag, input int n, input logic to_ic);
    logic [31:0] exp_d;
    for (int i = 0; i < n; i++) begin
      exp_d      = 32'hD000_0000 + 32'(i * 17);
      bus_rdata  = exp_d;
      bus_rvalid = 1'b1;
      bus_rlast  = (i == n - 1);
      sample();
      check({tag, " ret_data"}, ret_data, exp_d);
      check({tag, " ic_valid"}, {31'd0, ic_ret_valid}, {31'd0, to_ic});
      check({tag, " dc_valid"}, {31'd0, dc_ret_valid}, {31'd0, ~to_ic});
      check({tag, " ret_last"}, {31'd0, ret_last}, (i == n - 1) ? 32'd1 : 32'd0);
      check({tag, " rd gnt"},   {29'd0, ic_rd_gnt, dc_rd_gnt, dc_wr_gnt}, 32'd0);
      tick();
    end
    bus_rvalid = 1'b0;
    bus_rlast  = 1'b0;
    bus_rdata  = 32'd0;
  endtask

  // Drives write beats; pat bit k is bus_wready in the k-th data cycle (1 beyond bit 15).
  task automatic do_write(input string tag, input logic [LEN_W-1:0] len, input logic [15:0] pat);
    int   beat  = 0;
    int   k     = 0;
    int   nexts = 0;
    logic rdy;
    while (beat <= int'(len) && k < 32) begin
      rdy        = (k < 16) ? pat[k] : 1'b1;
      bus_wready = rdy;
      dc_wr_data = 32'hA500_0000 + 32'(beat);
      sample();
      check({tag, " wvalid"}, {31'd0, bus_wvalid}, 32'd1);
      check({tag, " wdata"},  bus_wdata, 32'hA500_0000 + 32'(beat));
      check({tag, " wlast"},  {31'd0, bus_wlast}, (beat == int'(len)) ? 32'd1 : 32'd0);
      check({tag, " wnext"},  {31'd0, dc_wr_next}, {31'd0, rdy});
      check({tag, " wr gnt"}, {29'd0, ic_rd_gnt, dc_rd_gnt, dc_wr_gnt}, 32'd0);
      if (dc_wr_next) nexts++;
      tick();
      if (rdy) beat++;
      k++;
    end
    bus_wready = 1'b0;
    check({tag, " wnext count"}, 32'(nexts), 32'(int'(len) + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc_n;
    rst        = 1'b1;
    ic_rd_req  = 1'b0; ic_rd_addr = '0; ic_rd_len = '0;
    dc_rd_req  = 1'b0; dc_rd_addr = '0; dc_rd_len = '0;
    dc_wr_req  = 1'b0; dc_wr_addr = '0; dc_wr_len = '0;
    dc_wr_data = '0;
    bus_ready  = 1'b0; bus_wready = 1'b0;
    bus_rdata  = '0;   bus_rvalid = 1'b0; bus_rlast = 1'b0;

    // Reset state
    tick(); tick();
    sample();
    check_quiet("reset");
    tick();
    rst = 1'b0;

    // 1: icache refill, ready on the second command cycle, 4 beats
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_0000; ic_rd_len = 3'd3;
    do_cmd("t1", 1'b0, 32'h1C00_0000, 3'd3, 1, 3'b100);
    do_read("t1", 4, 1'b1);
    sample();
    check_quiet("t1 idle");
    tick();

    // 2: write and read requested together -> write first
    dc_wr_req = 1'b1; dc_wr_addr = 32'h4000_0040; dc_wr_len = 3'd3;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h4000_0080; dc_rd_len = 3'd1;
    do_cmd("t2 wr", 1'b1, 32'h4000_0040, 3'd3, 0, 3'b001);
    do_write("t2 wr", 3'd3, 16'hFFFF);
    do_cmd("t2 rd", 1'b0, 32'h4000_0080, 3'd1, 0, 3'b010);
    do_read("t2 rd", 2, 1'b0);

    // 3: icache starved by back-to-back dcache reads, wins the 5th transaction
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_0300; ic_rd_len = 3'd0;
    dc_n = 0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h8000_0000; dc_rd_len = 3'd1;
    for (int t = 0; t < 7; t++) begin
      if (t == 4) begin
        check("t3 starve full", 32'(dut.starve_cnt_q), 32'd4);
        do_cmd("t3 ic", 1'b0, 32'h1C00_0300, 3'd0, 0, 3'b100);
        check("t3 starve clear", 32'(dut.starve_cnt_q), 32'd0);
        do_read("t3 ic", 1, 1'b1);
      end else begin
        do_cmd("t3 dc", 1'b0, 32'h8000_0000 + 32'(dc_n * 32), 3'd1, 0, 3'b010);
        do_read("t3 dc", 2, 1'b0);
        dc_n++;
        if (dc_n < 6) begin
          dc_rd_req  = 1'b1;
          dc_rd_addr = 32'h8000_0000 + 32'(dc_n * 32);
        end
      end
    end
    check("t3 starve end", 32'(dut.starve_cnt_q), 32'd0);

    // 4: write with bus_wready pattern 1,0,0,1,1,0,1
    dc_wr_req = 1'b1; dc_wr_addr = 32'h4000_0100; dc_wr_len = 3'd3;
    do_cmd("t4", 1'b1, 32'h4000_0100, 3'd3, 2, 3'b001);
    do_write("t4", 3'd3, 16'h0059);

    // 5: asynchronous reset mid-read, then re-arbitration of a pending icache request
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_0100; ic_rd_len = 3'd3;
    do_cmd("t5", 1'b0, 32'h1C00_0100, 3'd3, 0, 3'b100);
    for (int i = 0; i < 2; i++) begin
      bus_rvalid = 1'b1; bus_rlast = 1'b0; bus_rdata = 32'h5500_0000 + 32'(i);
      sample();
      check("t5 beat", {31'd0, ic_ret_valid}, 32'd1);
      tick();
    end
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C00_0200; ic_rd_len = 3'd1;
    bus_rvalid = 1'b1; bus_rdata = 32'h5500_0002;
    sample();
    check("t5 pre-rst beat", {31'd0, ic_ret_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_quiet("t5 async rst");
    check("t5 fsm idle", 32'(dut.state_q), 32'd0);
    bus_rvalid = 1'b0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    do_cmd("t5 rearb", 1'b0, 32'h1C00_0200, 3'd1, 0, 3'b100);
    do_read("t5 rearb", 2, 1'b1);

    // 6: single-beat uncached store
    dc_wr_req = 1'b1; dc_wr_addr = 32'h6000_0004; dc_wr_len = 3'd0;
    do_cmd("t6", 1'b1, 32'h6000_0004, 3'd0, 0, 3'b001);
    do_write("t6", 3'd0, 16'hFFFF);
    sample();
    check_quiet("t6 idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
